// File: rtl/outpass_scheduler.sv
// -----------------------------------------------------------------------------
// outpass_scheduler
//
// Shares a tile's four external output pins (O0..O3) among NUM_REQ fabric-side
// requesters. Ownership is granted round-robin for a whole burst. Beats move
// under a valid/ready handshake, and a configurable idle gap follows each
// burst. Each pin has its own registered/bypass output stage.
//
// Ports
//   UserCLK     in   fabric user clock, all state on the rising edge
//   RESETn      in   asynchronous, active-low reset
//   ConfigBits  in   [3:0] per-pin register enable (1 = registered pin)
//                    [5:4] idle gap cycles inserted after each burst (0..3)
//   req_valid   in   requester r has a beat available
//   req_len     in   burst length of requester r in [4r+3:4r] (0 means 16)
//   req_data    in   beat data of requester r in [4r+3:4r]
//   req_ready   out  one-hot; a beat is accepted on req_valid[r] & req_ready[r]
//   grant       out  one-hot owner of the pins, held for the whole burst
//   busy        out  scheduler is not idle
//   out_valid   out  an accepted beat is present on the bypass pins
//   O0..O3      out  external pins
// -----------------------------------------------------------------------------
module outpass_scheduler #(
   parameter int NUM_REQ      = 4,
   parameter int NoConfigBits = 6
) (
   input  logic                    UserCLK,
   input  logic                    RESETn,
   input  logic [NoConfigBits-1:0] ConfigBits,
   input  logic [NUM_REQ-1:0]      req_valid,
   input  logic [4*NUM_REQ-1:0]    req_len,
   input  logic [4*NUM_REQ-1:0]    req_data,
   output logic [NUM_REQ-1:0]      req_ready,
   output logic [NUM_REQ-1:0]      grant,
   output logic                    busy,
   output logic                    out_valid,
   output logic                    O0,
   output logic                    O1,
   output logic                    O2,
   output logic                    O3
);

   localparam int IDX_W = $clog2(NUM_REQ);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_XFER = 2'd1;
   localparam logic [1:0] S_GAP  = 2'd2;

   logic [1:0]         state_q,     state_d;
   logic [NUM_REQ-1:0] grant_q,     grant_d;
   logic [IDX_W-1:0]   winner_q,    winner_d;
   logic [IDX_W-1:0]   rr_ptr_q,    rr_ptr_d;
   logic [4:0]         cnt_q,       cnt_d;
   logic [1:0]         gap_q,       gap_d;
   logic [3:0]         out_d_q,     out_d_d;    // beat stage, drives bypass pins
   logic [3:0]         out_r_q;                 // one-cycle-later copy for registered pins
   logic               out_valid_q, out_valid_d;

   logic               arb_found;
   logic [IDX_W-1:0]   arb_idx;
   logic [IDX_W-1:0]   scan_idx;
   logic [3:0]         arb_len;
   logic [3:0]         beat_data;
   logic               accept;
   logic [1:0]         cfg_gap;
   logic [3:0]         pin_mux;

   // Index arithmetic modulo NUM_REQ; NUM_REQ need not be a power of two.
   function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                 input int unsigned      off);
      int unsigned s;
      s = 32'(base) + off;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      return s[IDX_W-1:0];
   endfunction

   assign cfg_gap = ConfigBits[5:4];

   // Round-robin pick: scan offsets from the highest down so that the
   // requester closest to rr_ptr (offset 0 first) is the last one written.
   always_comb begin
      // NOTE: every combinational output gets a default before any branch,
      // otherwise a path that skips the assignment infers a latch.
      arb_found = 1'b0;
      arb_idx   = '0;
      scan_idx  = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         scan_idx = wrap_add(rr_ptr_q, i);
         if (req_valid[scan_idx]) begin
            arb_found = 1'b1;
            arb_idx   = scan_idx;
         end
      end
   end

   assign arb_len   = req_len[{arb_idx, 2'b00} +: 4];
   assign beat_data = req_data[{winner_q, 2'b00} +: 4];
   // Only the owner's valid matters; everyone else is ignored outside IDLE.
   assign accept    = (state_q == S_XFER) && req_valid[winner_q];

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      winner_d    = winner_q;
      rr_ptr_d    = rr_ptr_q;
      cnt_d       = cnt_q;
      gap_d       = gap_q;
      out_d_d     = 4'b0;       // idle, gap and stall cycles drive zeros
      out_valid_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (arb_found) begin
               state_d  = S_XFER;
               grant_d  = {{(NUM_REQ-1){1'b0}}, 1'b1} << arb_idx;
               winner_d = arb_idx;
               rr_ptr_d = wrap_add(arb_idx, 1);
               cnt_d    = (arb_len == 4'd0) ? 5'd16 : {1'b0, arb_len};
            end
         end
         S_XFER: begin
            // A stall simply holds the grant; there is no timeout.
            if (accept) begin
               out_d_d     = beat_data;
               out_valid_d = 1'b1;
               cnt_d       = cnt_q - 5'd1;
               if (cnt_q == 5'd1) begin
                  grant_d = '0;
                  if (cfg_gap != 2'd0) begin
                     state_d = S_GAP;
                     gap_d   = cfg_gap;
                  end else begin
                     state_d = S_IDLE;
                  end
               end
            end
         end
         S_GAP: begin
            gap_d = gap_q - 2'd1;
            if (gap_q == 2'd1) state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            grant_d = '0;
         end
      endcase
   end

   // NOTE: the reset is asynchronous and covers every register, so the pins
   // drop to zero the moment RESETn falls, even mid-burst; the burst is lost.
   always_ff @(posedge UserCLK or negedge RESETn) begin
      if (!RESETn) begin
         state_q     <= S_IDLE;
         grant_q     <= '0;
         winner_q    <= '0;
         rr_ptr_q    <= '0;
         cnt_q       <= '0;
         gap_q       <= '0;
         out_d_q     <= '0;
         out_r_q     <= '0;
         out_valid_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments make every register sample the
         // pre-edge values, so out_r_q really takes the old out_d_q.
         state_q     <= state_d;
         grant_q     <= grant_d;
         winner_q    <= winner_d;
         rr_ptr_q    <= rr_ptr_d;
         cnt_q       <= cnt_d;
         gap_q       <= gap_d;
         out_d_q     <= out_d_d;
         out_r_q     <= out_d_q;
         out_valid_q <= out_valid_d;
      end
   end

   // grant is only non-zero in XFER, so ready is purely registered state and
   // never depends combinationally on req_valid.
   assign req_ready = grant_q;
   assign grant     = grant_q;
   assign busy      = (state_q != S_IDLE);
   assign out_valid = out_valid_q;

   // Per-pin output stage; ConfigBits may change at any time and acts at once.
   assign pin_mux = (ConfigBits[3:0] & out_r_q) | (~ConfigBits[3:0] & out_d_q);
   assign O0 = pin_mux[0];
   assign O1 = pin_mux[1];
   assign O2 = pin_mux[2];
   assign O3 = pin_mux[3];

endmodule
